som_multibyte_seq: RTL

//   Sequencer wrapping the 8-bit combinational adder som_comp_8bit (x, y, Cin -> A, Cout).
//   - Operates on NBYTES-wide operands. Each byte pair goes through the adder in turn, LSB byte first.
//   - The carry between bytes is held in a register.
//   - Sits on both sides of the adder: it drives the x/y/Cin inputs and collects the A/Cout outputs.
//   - Provides a start/done handshake to the controlling logic.

---
 rtl/som_multibyte_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/som_multibyte_seq.sv
// Byte-serial sequencer around the 8-bit combinational adder som_comp_8bit.
// Optional SOM_SUB_EN adds a sub port for A-B via inverted B and forced carry.
module som_multibyte_seq #(
   parameter int NBYTES = 4,
   localparam int W = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         cin,
`ifdef SOM_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout,
   output logic [7:0]   x,
   output logic [7:0]   y,
   output logic         Cin,
   input  logic [7:0]   A,
   input  logic         Cout
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    result_q, result_d;
   logic            cout_q, cout_d;
   logic            sub_q, sub_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         sub_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         sub_q    <= sub_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      sub_d    = sub_q;
      busy     = 1'b0;
      done     = 1'b0;
      x        = '0;
      y        = '0;
      Cin      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = op_a;
               b_d      = op_b;
               result_d = '0;
               idx_d    = '0;
`ifdef SOM_SUB_EN
               sub_d    = sub;
               carry_d  = sub | cin;
`else
               sub_d    = 1'b0;
               carry_d  = cin;
`endif
               state_d  = ADD;
            end
         end
         ADD: begin
            busy = 1'b1;
            x    = a_q[{idx_q, 3'b000} +: 8];
            // Subtraction feeds the one's complement of B; the +1 is the forced carry.
            y    = sub_q ? ~b_q[{idx_q, 3'b000} +: 8] : b_q[{idx_q, 3'b000} +: 8];
            Cin  = carry_q;
            result_d[{idx_q, 3'b000} +: 8] = A;
            carry_d = Cout;
            if (idx_q == LAST) begin
               cout_d  = Cout;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign result = result_q;
   assign cout   = cout_q;

endmodule
